// File: rtl/sram_like_responder.sv
// sram_like_responder
//   In-order SRAM-style target with a fixed per-transaction service time.
//   Requests are accepted into a small FIFO whenever it has room; the head
//   entry is serviced for LATENCY cycles and then completes with a one-cycle
//   data_ok pulse. Reads return the word at completion time, and writes
//   commit their enabled bytes on the completion edge.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset (memory array is kept)
//   req      in   1   request valid
//   wr       in   1   1 = write, 0 = read
//   size     in   2   access size, carried for tracing only
//   wstrb    in   4   byte write enables for writes
//   addr     in  32   byte address; word index is addr[ADDR_WIDTH+1:2]
//   wdata    in  32   write data
//   addr_ok  out  1   request accepted this cycle when req && addr_ok
//   data_ok  out  1   completion pulse for the oldest outstanding request
//   rdata    out 32   read data, non-zero only on a read completion
module sram_like_responder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int LATENCY     = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int WORDS = 1 << ADDR_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
   localparam logic [3:0]       LAT_LAST = 4'(LATENCY - 1);

   // Transaction FIFO storage
   logic                  fifo_wr_r   [QUEUE_DEPTH];
   logic [3:0]            fifo_strb_r [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_idx_r  [QUEUE_DEPTH];
   logic [31:0]           fifo_data_r [QUEUE_DEPTH];

   // Backing store; intentionally never reset
   logic [31:0] mem_r [WORDS];

   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic [3:0]       cnt_r;

   logic [CNT_W-1:0] count_next_s;
   logic [3:0]       cnt_next_s;
   logic             accept_s;
   logic             retire_s;
   logic             head_wr_s;
   logic [3:0]       head_strb_s;
   logic [ADDR_WIDTH-1:0] head_idx_s;
   logic [31:0]      head_data_s;
   logic             unused_s;

   // size and the ignored address bits are deliberately not used
   assign unused_s = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};

   assign head_wr_s   = fifo_wr_r[head_r];
   assign head_strb_s = fifo_strb_r[head_r];
   assign head_idx_s  = fifo_idx_r[head_r];
   assign head_data_s = fifo_data_r[head_r];

   // Handshake outputs: derived from registered state, forced low while in reset.
   // addr_ok looks only at the current count, so a same-cycle retire never
   // opens a slot in a full queue.
   always_comb begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (reset) begin
         addr_ok = 1'b0;
         data_ok = 1'b0;
      end else begin
         addr_ok = (count_r < DEPTH_C);
         data_ok = (count_r != {CNT_W{1'b0}}) && (cnt_r == LAT_LAST);
      end
   end

   assign accept_s = req && addr_ok;
   assign retire_s = data_ok;

   // Read data: memory word at the head index, only on a read completion
   always_comb begin
      rdata = 32'h0000_0000;
      if (data_ok && !head_wr_s) begin
         rdata = mem_r[head_idx_s];
      end else begin
         rdata = 32'h0000_0000;
      end
   end

   // Next occupancy count and head timer
   always_comb begin
      count_next_s = count_r;
      cnt_next_s   = cnt_r;
      case ({accept_s, retire_s})
         2'b10:   count_next_s = count_r + CNT_W'(1);
         2'b01:   count_next_s = count_r - CNT_W'(1);
         default: count_next_s = count_r;
      endcase
      // Timer restarts whenever the head changes or the queue is empty, so a
      // newly promoted head always starts at zero.
      if (retire_s || (count_r == {CNT_W{1'b0}})) begin
         cnt_next_s = 4'd0;
      end else begin
         cnt_next_s = cnt_r + 4'd1;
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         cnt_r   <= 4'd0;
      end else begin
         count_r <= count_next_s;
         cnt_r   <= cnt_next_s;
         if (accept_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (retire_s) begin
            head_r <= head_r + PTR_W'(1);
         end
      end
   end

   // FIFO payload capture at the tail on acceptance
   always_ff @(posedge clk) begin
      if (accept_s) begin
         fifo_wr_r[tail_r]   <= wr;
         fifo_strb_r[tail_r] <= wstrb;
         fifo_idx_r[tail_r]  <= addr[ADDR_WIDTH+1:2];
         fifo_data_r[tail_r] <= wdata;
      end
   end

   // Byte-merged memory write when a write completes
   always_ff @(posedge clk) begin
      if (retire_s && head_wr_s) begin
         for (int i = 0; i < 4; i++) begin
            if (head_strb_s[i]) begin
               mem_r[head_idx_s][8*i +: 8] <= head_data_s[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;

   localparam int AW    = 12;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   sram_like_responder #(
      .ADDR_WIDTH (AW),
      .LATENCY    (LAT),
      .QUEUE_DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .wr     (wr),
      .size   (size),
      .wstrb  (wstrb),
      .addr   (addr),
      .wdata  (wdata),
      .addr_ok(addr_ok),
      .data_ok(data_ok),
      .rdata  (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      int          idx;
      logic [3:0]  strb;
      logic [31:0] data;
      int          due;
   } txn_t;

   txn_t        q[$];
   logic [31:0] mem_m [1 << AW];
   int          cyc;
   int          last_due;
   logic [31:0] last_rd;
   int          n_pass;
   int          n_total;
   bit          exp_dok;
   logic [31:0] exp_rd;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor/scoreboard: checks outputs mid-cycle against the reference queue
   always @(negedge clk) begin
      if (reset) begin
         check("addr_ok_rst", 32'(addr_ok), 32'd0);
         check("data_ok_rst", 32'(data_ok), 32'd0);
         check("rdata_rst", rdata, 32'd0);
         q.delete();
         last_due = -100;
      end else begin
         exp_dok = (q.size() != 0) && (q[0].due == cyc);
         check("addr_ok", 32'(addr_ok), 32'(q.size() < DEPTH));
         check("data_ok", 32'(data_ok), 32'(exp_dok));
         exp_rd = 32'd0;
         if (exp_dok && !q[0].is_wr) exp_rd = mem_m[q[0].idx];
         check("rdata", rdata, exp_rd);
         if (exp_dok) begin
            if (q[0].is_wr) begin
               for (int i = 0; i < 4; i++)
                  if (q[0].strb[i]) mem_m[q[0].idx][8*i +: 8] = q[0].data[8*i +: 8];
            end else begin
               last_rd = rdata;
            end
            void'(q.pop_front());
         end
      end
   end

   // Issue one request, holding req until accepted; starts and ends at posedge+1
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int   tries;
      int   hs;
      txn_t t;
      tries = 0;
      req   = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      wstrb = s;
      size  = 2'($urandom_range(2, 0));
      forever begin
         @(negedge clk);
         #1;
         if (addr_ok) begin
            hs = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
            t.is_wr = w;
            t.idx   = int'((a >> 2) % (32'd1 << AW));
            t.strb  = s;
            t.data  = d;
            t.due   = hs + LAT - 1;
            last_due = t.due;
            q.push_back(t);
            break;
         end
         tries++;
         if (tries > 50) begin
            check("accept_timeout", 32'(tries), 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 200) begin
         idle(1);
         k++;
      end
      check("drain", 32'(q.size()), 32'd0);
      idle(1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      req   = 1'b0;
      idle(1);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr(input int idx);
      return ($urandom() & 32'hFFFF_C003) | (32'(idx) << 2);
   endfunction

   logic [31:0] saved;

   initial begin
      cyc      = 0;
      n_pass   = 0;
      n_total  = 0;
      last_due = -100;
      last_rd  = 32'd0;
      reset    = 1'b1;
      req      = 1'b0;
      wr       = 1'b0;
      size     = 2'd0;
      wstrb    = 4'h0;
      addr     = 32'd0;
      wdata    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // Initialise the word range used by random traffic
      for (int i = 0; i < 16; i++) issue(1'b1, 32'(i) << 2, $urandom(), 4'hF);
      drain();

      // Write then read back
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      drain();
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      drain();
      check("wr_rd_basic", last_rd, 32'hDEADBEEF);

      // Byte merge and zero-strobe write
      issue(1'b1, 32'h10, 32'h000000AA, 4'h1);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      drain();
      check("byte_merge", last_rd, 32'hDEADBEAA);
      issue(1'b1, 32'h10, 32'h12345678, 4'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      drain();
      check("zero_strobe", last_rd, 32'hDEADBEAA);

      // Read-before-write and write-then-read ordering
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b1, 32'h20, 32'h11111111, 4'hF);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      drain();
      check("raw_order", last_rd, 32'h11111111);

      // Aliasing of address bits above the word index
      issue(1'b1, 32'h0000_4010, 32'hCAFEF00D, 4'hF);
      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      drain();
      check("alias", last_rd, 32'hCAFEF00D);

      // Full queue with req held high back to back
      for (int i = 0; i < 8; i++) issue(1'b0, 32'(i) << 2, 32'h0, 4'h0);
      drain();

      // Reset with writes outstanding: nothing completes or commits
      saved = mem_m[3];
      issue(1'b1, 32'h4, 32'hA1A1A1A1, 4'hF);
      issue(1'b1, 32'h8, 32'hB2B2B2B2, 4'hF);
      issue(1'b1, 32'hC, 32'hC3C3C3C3, 4'hF);
      pulse_reset();
      issue(1'b0, 32'h4, 32'h0, 4'h0);
      issue(1'b0, 32'h8, 32'h0, 4'h0);
      issue(1'b0, 32'hC, 32'h0, 4'h0);
      drain();
      check("reset_discard", last_rd, saved);

      // Randomised traffic with idle gaps and occasional resets
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(99, 0) < 2) pulse_reset();
         else if ($urandom_range(99, 0) < 20) idle(int'($urandom_range(3, 1)));
         else issue(1'($urandom_range(1, 0)), rand_addr(int'($urandom_range(15, 0))),
                    $urandom(), 4'($urandom_range(15, 0)));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
